// File: rtl/amba_pkg.sv
// Shared types for the APB request queue: request payload and sequencer states.
package amba_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  // One queued APB request as stored in the FIFO and the command register.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } req_state_e;

endpackage

// File: rtl/apb_sync_fifo.sv
// Synchronous FIFO, generic over payload type, exposing its occupancy.
// Full and empty are derived from the level; pointers wrap naturally.
module apb_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: the storage array has no reset -- occupancy is tracked by level, so clearing it buys nothing.
  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments in clocked blocks keep every register sampling pre-edge values.
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves level unchanged.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/apb_req_queue.sv
// Request queue and issue sequencer in front of the APB master.
// Buffers requests, issues one at a time, returns one response each.
// Optional access timeout: define APB_REQ_TIMEOUT_EN.
module apb_req_queue
  import amba_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       transfer,
  output logic                       mpwrite,
  output logic [ADDR_W-1:0]          apb_write_paddr,
  output logic [DATA_W-1:0]          apb_write_data,
  output logic [ADDR_W-1:0]          apb_read_paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pready,
  input  logic [DATA_W-1:0]          apb_read_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  req_state_e state_q;
  req_state_e state_d;
  apb_req_t   push_req;
  apb_req_t   head_req;
  apb_req_t   cmd_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       done;
  logic       timed_out;
  logic       tmo_hit;

  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = ~fifo_full;

  apb_sync_fifo #(
    .T     (apb_req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pclk      (pclk),
    .preset    (preset),
    .push      (req_valid & req_ready),
    .push_data (push_req),
    .pop       (pop),
    .head      (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // The active command drives both address buses; the master picks by direction.
  assign mpwrite         = cmd_q.write;
  assign apb_write_paddr = cmd_q.addr;
  assign apb_read_paddr  = cmd_q.addr;
  assign apb_write_data  = cmd_q.wdata;

  // Next-state and strobes for the issue sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    pop       = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The response slot must be free so only one request is ever in flight.
        if (!fifo_empty && !rsp_valid) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmo_hit) begin
          timed_out = 1'b1;
          state_d   = ST_RESP;
        end else if (psel && !penable) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (psel && penable && pready) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          timed_out = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge pclk) begin
    if (preset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Command register and transfer request: raised on pop, dropped when the access ends.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cmd_q    <= '0;
      transfer <= 1'b0;
    end else if (pop) begin
      cmd_q    <= head_req;
      transfer <= 1'b1;
    end else if (done || timed_out) begin
      transfer <= 1'b0;
    end
  end

  // Response register: loaded as the access finishes, held until consumed.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else if (done || timed_out) begin
      rsp_valid <= 1'b1;
      rsp_write <= cmd_q.write;
      rsp_rdata <= (done && !cmd_q.write) ? apb_read_data_out : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT+1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_err_q;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT-1));
  assign rsp_err = rsp_err_q;

  // Cycles spent in SETUP/ACCESS for the current command; restarts on each issue.
  always_ff @(posedge pclk) begin
    if (preset || pop) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Error flag travels with the response payload.
  always_ff @(posedge pclk) begin
    if (preset)                 rsp_err_q <= 1'b0;
    else if (done || timed_out) rsp_err_q <= timed_out;
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_queue.sv
// Directed self-checking bench for apb_req_queue with a small APB master/slave model.
// The timeout scenario runs only when APB_REQ_TIMEOUT_EN is defined.
module tb_apb_req_queue;

  logic       pclk;
  logic       preset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       transfer;
  logic       mpwrite;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic       psel;
  logic       penable;
  logic       pready;
  logic [7:0] apb_read_data_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

  int         wait_states = 0;
  bit         stuck = 1'b0;
  int         wcnt;
  logic [7:0] slave_mem [512];

  apb_req_queue #(
    .ADDR_W  (9),
    .DATA_W  (8),
    .DEPTH   (8),
    .TIMEOUT (4)
  ) dut (
    .pclk              (pclk),
    .preset            (preset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .transfer          (transfer),
    .mpwrite           (mpwrite),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .psel              (psel),
    .penable           (penable),
    .pready            (pready),
    .apb_read_data_out (apb_read_data_out),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_write         (rsp_write),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .level             (level)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Master phase model plus a memory slave with programmable wait states.
  always @(posedge pclk) begin
    if (preset) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      wcnt    <= 0;
    end else if (!psel) begin
      if (transfer) psel <= 1'b1;
    end else if (!penable) begin
      penable <= 1'b1;
      wcnt    <= 0;
    end else if (pready) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      if (mpwrite) slave_mem[apb_write_paddr] <= apb_write_data;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  assign pready            = psel & penable & ~stuck & (wcnt >= wait_states);
  assign apb_read_data_out = slave_mem[apb_read_paddr];

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
  endtask

  task automatic take_rsp(output logic w, output logic [7:0] d, output logic e);
    w = rsp_write;
    d = rsp_rdata;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  task automatic push_one(input logic w, input logic [8:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    checks++;
    if ({req_ready, transfer, mpwrite, rsp_valid, rsp_write, rsp_err} !== 6'b100000)
      $display("FAIL reset_flags: got %b expected 100000", {req_ready, transfer, mpwrite, rsp_valid, rsp_write, rsp_err});
    if ({req_ready, transfer, mpwrite, rsp_valid, rsp_write, rsp_err} !== 6'b100000) errors++;
    checks++;
    if (apb_write_paddr !== 9'h0 || apb_read_paddr !== 9'h0 || apb_write_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_bus: waddr=%h raddr=%h wdata=%h expected all 0", apb_write_paddr, apb_read_paddr, apb_write_data);
    end
    checks++;
    if (rsp_rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
    end
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
    preset = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_single_write();
    int         on_cycles = 0;
    bit         seen = 1'b0;
    logic       w;
    logic [7:0] d;
    logic       e;
    wait_states = 0;
    push_one(1'b1, 9'h005, 8'hA5);
    checks++;
    if (transfer !== 1'b0 || level !== 4'd1) begin
      errors++;
      $display("FAIL sw_push: transfer=%b level=%0d expected transfer=0 level=1", transfer, level);
    end
    @(negedge pclk);
    checks++;
    if (transfer !== 1'b1 || mpwrite !== 1'b1 || apb_write_paddr !== 9'h005 ||
        apb_read_paddr !== 9'h005 || apb_write_data !== 8'hA5 || level !== 4'd0) begin
      errors++;
      $display("FAIL sw_issue: transfer=%b mpwrite=%b waddr=%h wdata=%h level=%0d expected 1 1 005 a5 0",
               transfer, mpwrite, apb_write_paddr, apb_write_data, level);
    end
    for (int i = 0; i < 20; i++) begin
      if (transfer && psel) on_cycles++;
      if (psel && penable && pready) begin
        seen = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL sw_rsp_early: rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 1'b1 || transfer !== 1'b0) begin
          errors++;
          $display("FAIL sw_rsp_timing: rsp_valid=%b transfer=%b expected 1 0", rsp_valid, transfer);
        end
        break;
      end
      @(negedge pclk);
    end
    checks++;
    if (!seen || on_cycles != 2) begin
      errors++;
      $display("FAIL sw_transfer_cycles: completed=%b cycles=%0d expected 1 2", seen, on_cycles);
    end
    take_rsp(w, d, e);
    checks++;
    if (w !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_rsp: write=%b rdata=%h err=%b expected 1 00 0", w, d, e);
    end
  endtask

  task automatic test_write_read();
    bit         ok;
    logic       w;
    logic [7:0] d;
    logic       e;
    push_one(1'b1, 9'h010, 8'h3C);
    push_one(1'b0, 9'h010, 8'hFF);
    wait_valid(40, ok);
    take_rsp(w, d, e);
    checks++;
    if (!ok || w !== 1'b1 || d !== 8'h00 || e !== 1'b0) begin
      errors++;
      $display("FAIL wr_first: seen=%b write=%b rdata=%h err=%b expected 1 1 00 0", ok, w, d, e);
    end
    wait_valid(40, ok);
    take_rsp(w, d, e);
    checks++;
    if (!ok || w !== 1'b0 || d !== 8'h3C || e !== 1'b0) begin
      errors++;
      $display("FAIL wr_read: seen=%b write=%b rdata=%h err=%b expected 1 0 3c 0", ok, w, d, e);
    end
  endtask

  task automatic test_fill();
    bit         ok;
    bit         extra = 1'b0;
    logic       w;
    logic [7:0] d;
    logic       e;
    logic       exp_w;
    logic [7:0] exp_d;
    rsp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready_%0d: req_ready=%b expected 1", i, req_ready);
      end
      if (i < 5) push_one(1'b1, 9'(32 + i), 8'(80 + i));
      else       push_one(1'b0, 9'(32 + i - 5), 8'h00);
    end
    checks++;
    if (level !== 4'd8 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: level=%0d req_ready=%b expected 8 0", level, req_ready);
    end
    push_one(1'b1, 9'h07F, 8'hEE);
    checks++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL fill_overflow: level=%0d expected 8", level);
    end
    for (int i = 0; i < 9; i++) begin
      exp_w = (i < 5);
      exp_d = (i < 5) ? 8'h00 : 8'(80 + i - 5);
      wait_valid(40, ok);
      take_rsp(w, d, e);
      checks++;
      if (!ok || w !== exp_w || d !== exp_d || e !== 1'b0) begin
        errors++;
        $display("FAIL fill_rsp_%0d: seen=%b write=%b rdata=%h err=%b expected 1 %b %h 0",
                 i, ok, w, d, e, exp_w, exp_d);
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) extra = 1'b1;
      @(negedge pclk);
    end
    checks++;
    if (extra || level !== 4'd0) begin
      errors++;
      $display("FAIL fill_drain: extra_rsp=%b level=%0d expected 0 0", extra, level);
    end
  endtask

  task automatic test_wait_states();
    int         on_cycles = 0;
    bit         dropped = 1'b0;
    bit         seen = 1'b0;
    bit         extra = 1'b0;
    logic       w;
    logic [7:0] d;
    logic       e;
    wait_states = 3;
    push_one(1'b0, 9'h020, 8'h00);
    for (int i = 0; i < 30; i++) begin
      if (psel && !transfer) dropped = 1'b1;
      if (transfer && psel) on_cycles++;
      if (psel && penable && pready) begin
        seen = 1'b1;
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL ws_rsp_timing: rsp_valid=%b expected 1", rsp_valid);
        end
        break;
      end
      @(negedge pclk);
    end
    checks++;
    if (!seen || dropped || on_cycles != 5) begin
      errors++;
      $display("FAIL ws_hold: completed=%b dropped=%b cycles=%0d expected 1 0 5", seen, dropped, on_cycles);
    end
    take_rsp(w, d, e);
    checks++;
    if (w !== 1'b0 || d !== 8'h50 || e !== 1'b0) begin
      errors++;
      $display("FAIL ws_rsp: write=%b rdata=%h err=%b expected 0 50 0", w, d, e);
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b0) extra = 1'b1;
      @(negedge pclk);
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL ws_single: extra response seen, expected none");
    end
    wait_states = 0;
  endtask

`ifdef APB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    bit         ok;
    logic       w;
    logic [7:0] d;
    logic       e;
    stuck = 1'b1;
    push_one(1'b0, 9'h021, 8'h00);
    push_one(1'b1, 9'h022, 8'h77);
    wait_valid(30, ok);
    checks++;
    if (!ok || transfer !== 1'b0) begin
      errors++;
      $display("FAIL to_drop: seen=%b transfer=%b expected 1 0", ok, transfer);
    end
    stuck = 1'b0;
    take_rsp(w, d, e);
    checks++;
    if (w !== 1'b0 || d !== 8'h00 || e !== 1'b1) begin
      errors++;
      $display("FAIL to_rsp: write=%b rdata=%h err=%b expected 0 00 1", w, d, e);
    end
    wait_valid(40, ok);
    take_rsp(w, d, e);
    checks++;
    if (!ok || w !== 1'b1 || d !== 8'h00 || e !== 1'b0 || slave_mem[9'h022] !== 8'h77) begin
      errors++;
      $display("FAIL to_next: seen=%b write=%b rdata=%h err=%b mem=%h expected 1 1 00 0 77",
               ok, w, d, e, slave_mem[9'h022]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit reached = 1'b0;
    bit activity = 1'b0;
    wait_states = 20;
    for (int i = 0; i < 4; i++) push_one(1'b1, 9'(48 + i), 8'(i));
    for (int i = 0; i < 20; i++) begin
      if (psel && penable) begin
        reached = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    checks++;
    if (!reached || level !== 4'd3) begin
      errors++;
      $display("FAIL rm_access: reached=%b level=%0d expected 1 3", reached, level);
    end
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    checks++;
    if (level !== 4'd0 || transfer !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_flush: level=%0d transfer=%b rsp_valid=%b expected 0 0 0", level, transfer, rsp_valid);
    end
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid !== 1'b0 || transfer !== 1'b0) activity = 1'b1;
      @(negedge pclk);
    end
    checks++;
    if (activity) begin
      errors++;
      $display("FAIL rm_quiet: response or transfer after reset, expected none");
    end
    wait_states = 0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) slave_mem[i] = 8'h00;
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_write();
    test_write_read();
    test_fill();
    test_wait_states();
`ifdef APB_REQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
